desc_matcher_nn: RTL and testbench

DESC_MATCHER_NN -- requirements
Module: desc_matcher_nn

---
 rtl/match_pkg.sv | 21 ++
 rtl/desc_sad_tree.sv | 71 +++++++
 rtl/desc_matcher_nn.sv | 145 ++++++++++++++
 tb/tb_desc_matcher_nn.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared FSM encoding and width/latency derivations for the descriptor matcher.
package match_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

   function automatic int clog2i(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int dist_w(input int n, input int w);
      return w + clog2i(n);
   endfunction

   function automatic int lat_of(input int n);
      return clog2i(n) + 1;
   endfunction

endpackage

// File: rtl/desc_sad_tree.sv
// Pipelined sum-of-absolute-differences tree: one register stage of |a-b|, then one per adder level.
module desc_sad_tree
   import match_pkg::*;
#(
   parameter int NUM_ELEM = 128,
   parameter int ELEM_W   = 10,
   parameter int IDX_W    = 11,
   localparam int DIST_W  = dist_w(NUM_ELEM, ELEM_W),
   localparam int LAT     = lat_of(NUM_ELEM)
)(
   input  logic                       iclk,
   input  logic                       irst,
   input  logic                       vld,
   input  logic [NUM_ELEM*ELEM_W-1:0] base,
   input  logic [NUM_ELEM*ELEM_W-1:0] desc,
   input  logic [IDX_W-1:0]           idx,
   output logic                       res_vld,
   output logic [DIST_W-1:0]          res_dist,
   output logic [IDX_W-1:0]           res_idx
);

   localparam int L  = LAT - 1;
   localparam int NP = 1 << L;

   function automatic logic [ELEM_W-1:0] abs_diff(input logic [ELEM_W-1:0] a,
                                                   input logic [ELEM_W-1:0] b);
      logic signed [ELEM_W:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return d[ELEM_W] ? ELEM_W'(-d) : d[ELEM_W-1:0];
   endfunction

   logic [L:0]       vld_p;
   logic [IDX_W-1:0] idx_p [0:L];

   for (genvar k = 0; k <= L; k++) begin : g_lvl
      logic [DIST_W-1:0] sum_p [0:(NP>>k)-1];
      if (k == 0) begin : g_leaf
         // leaves beyond NUM_ELEM pad the tree to a power of two with zeros
         always_ff @(posedge iclk) begin
            for (int i = 0; i < NUM_ELEM; i++)
               sum_p[i] <= DIST_W'(abs_diff(base[i*ELEM_W +: ELEM_W], desc[i*ELEM_W +: ELEM_W]));
            for (int i = NUM_ELEM; i < NP; i++)
               sum_p[i] <= '0;
         end
      end else begin : g_add
         always_ff @(posedge iclk) begin
            for (int j = 0; j < (NP >> k); j++)
               sum_p[j] <= g_lvl[k-1].sum_p[2*j] + g_lvl[k-1].sum_p[2*j+1];
         end
      end
   end

   always_ff @(posedge iclk or negedge irst) begin
      if (!irst) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= vld;
         for (int k = 1; k <= L; k++) vld_p[k] <= vld_p[k-1];
      end
   end

   always_ff @(posedge iclk) begin
      idx_p[0] <= idx;
      for (int k = 1; k <= L; k++) idx_p[k] <= idx_p[k-1];
   end

   assign res_vld  = vld_p[L];
   assign res_dist = g_lvl[L].sum_p[0];
   assign res_idx  = idx_p[L];

endmodule

// File: rtl/desc_matcher_nn.sv
// Nearest-neighbour matcher: streams scene descriptors against a template, tracks best/second SAD, ratio test.
module desc_matcher_nn
   import match_pkg::*;
#(
   parameter int NUM_ELEM    = 128,
   parameter int ELEM_W      = 10,
   parameter int IDX_W       = 11,
   parameter int RATIO_SHIFT = 1,
   localparam int DIST_W     = dist_w(NUM_ELEM, ELEM_W)
)(
   input  logic                       iclk,
   input  logic                       irst,
   input  logic                       i_base_load,
   input  logic [NUM_ELEM*ELEM_W-1:0] i_base_desc,
   input  logic                       i_start,
   input  logic [IDX_W-1:0]           i_scene_cnt,
   input  logic                       i_s_valid,
   output logic                       o_s_ready,
   input  logic [NUM_ELEM*ELEM_W-1:0] i_s_desc,
   input  logic [IDX_W-1:0]           i_s_idx,
   output logic                       o_busy,
   output logic                       o_valid,
   output logic                       o_matched,
   output logic [IDX_W-1:0]           o_best_idx,
   output logic [DIST_W-1:0]          o_best_dist,
   output logic [DIST_W-1:0]          o_second_dist
);

   state_t                     state;
   logic [NUM_ELEM*ELEM_W-1:0] base_reg;
   logic [IDX_W-1:0]           scene_cnt;
   logic [IDX_W-1:0]           acc_cnt;
   logic [IDX_W-1:0]           res_cnt;
   logic [IDX_W-1:0]           res_cnt_nx;
   logic                       hs;
   logic                       res_vld;
   logic [DIST_W-1:0]          res_dist;
   logic [IDX_W-1:0]           res_idx;
   logic [DIST_W-1:0]          best_nx;
   logic [DIST_W-1:0]          second_nx;
   logic [IDX_W-1:0]           idx_nx;

   assign hs         = i_s_valid && o_s_ready;
   assign res_cnt_nx = res_cnt + IDX_W'(1);

   desc_sad_tree #(
      .NUM_ELEM (NUM_ELEM),
      .ELEM_W   (ELEM_W),
      .IDX_W    (IDX_W)
   ) u_tree (
      .iclk     (iclk),
      .irst     (irst),
      .vld      (hs),
      .base     (base_reg),
      .desc     (i_s_desc),
      .idx      (i_s_idx),
      .res_vld  (res_vld),
      .res_dist (res_dist),
      .res_idx  (res_idx)
   );

   // strict compares: an equal distance never displaces the earlier best index
   always_comb begin
      best_nx   = o_best_dist;
      second_nx = o_second_dist;
      idx_nx    = o_best_idx;
      if (res_vld) begin
         if (res_dist < o_best_dist) begin
            second_nx = o_best_dist;
            best_nx   = res_dist;
            idx_nx    = res_idx;
         end else if (res_dist < o_second_dist) begin
            second_nx = res_dist;
         end
      end
   end

   always_ff @(posedge iclk or negedge irst) begin
      if (!irst) begin
         state         <= IDLE;
         base_reg      <= '0;
         scene_cnt     <= '0;
         acc_cnt       <= '0;
         res_cnt       <= '0;
         o_s_ready     <= 1'b0;
         o_busy        <= 1'b0;
         o_valid       <= 1'b0;
         o_matched     <= 1'b0;
         o_best_idx    <= '0;
         o_best_dist   <= '1;
         o_second_dist <= '1;
      end else begin
         o_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (i_base_load) base_reg <= i_base_desc;
               if (i_start) begin
                  scene_cnt     <= i_scene_cnt;
                  acc_cnt       <= '0;
                  res_cnt       <= '0;
                  o_best_dist   <= '1;
                  o_second_dist <= '1;
                  o_best_idx    <= '0;
                  o_matched     <= 1'b0;
                  o_busy        <= 1'b1;
                  if (i_scene_cnt != '0) begin
                     state     <= RUN;
                     o_s_ready <= 1'b1;
                  end else begin
                     state   <= REPORT;
                     o_valid <= 1'b1;
                  end
               end
            end
            RUN, DRAIN: begin
               o_best_dist   <= best_nx;
               o_second_dist <= second_nx;
               o_best_idx    <= idx_nx;
               if (res_vld) res_cnt <= res_cnt_nx;
               if (state == RUN && hs) begin
                  acc_cnt <= acc_cnt + IDX_W'(1);
                  if (acc_cnt + IDX_W'(1) == scene_cnt) begin
                     state     <= DRAIN;
                     o_s_ready <= 1'b0;
                  end
               end
               // last result lands: decide the ratio test on the values being written now
               if (res_vld && res_cnt_nx == scene_cnt) begin
                  state     <= REPORT;
                  o_s_ready <= 1'b0;
                  o_valid   <= 1'b1;
                  o_matched <= (res_cnt_nx >= IDX_W'(2)) &&
                               (best_nx < (second_nx >> RATIO_SHIFT));
               end
            end
            REPORT: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_desc_matcher_nn.sv
// Self-checking bench for desc_matcher_nn: directed table, corner sequences, randomized passes vs. a reference model.
module tb_desc_matcher_nn;

   localparam int NE   = 128;
   localparam int EW   = 10;
   localparam int DW   = NE * EW;
   localparam int LAT  = 8;
   localparam int ONES = 131071;

   logic          iclk = 1'b0;
   logic          irst = 1'b1;
   logic          i_base_load = 1'b0;
   logic [DW-1:0] i_base_desc = '0;
   logic          i_start = 1'b0;
   logic [10:0]   i_scene_cnt = '0;
   logic          i_s_valid = 1'b0;
   logic          o_s_ready;
   logic [DW-1:0] i_s_desc = '0;
   logic [10:0]   i_s_idx = '0;
   logic          o_busy, o_valid, o_matched;
   logic [10:0]   o_best_idx;
   logic [16:0]   o_best_dist, o_second_dist;

   desc_matcher_nn dut (
      .iclk          (iclk),
      .irst          (irst),
      .i_base_load   (i_base_load),
      .i_base_desc   (i_base_desc),
      .i_start       (i_start),
      .i_scene_cnt   (i_scene_cnt),
      .i_s_valid     (i_s_valid),
      .o_s_ready     (o_s_ready),
      .i_s_desc      (i_s_desc),
      .i_s_idx       (i_s_idx),
      .o_busy        (o_busy),
      .o_valid       (o_valid),
      .o_matched     (o_matched),
      .o_best_idx    (o_best_idx),
      .o_best_dist   (o_best_dist),
      .o_second_dist (o_second_dist)
   );

   always #5 iclk = ~iclk;

   typedef struct {
      int base_v; int cnt;
      int v[4]; int n[4]; int idx[4];
      int e_best; int e_second; int e_idx; int e_m;
   } vec_t;

   int tests = 0, fails = 0;
   int r_best, r_second, r_idx, r_m, r_lat;
   logic [DW-1:0] sc_desc [0:7];
   int sc_idx [0:7], sc_gap [0:7], sc_dist [0:7];
   int pulse_j = -1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk_desc(input int v, input int n);
      logic [DW-1:0] d;
      d = '0;
      for (int e = 0; e < NE; e++) if (e < n) d[e*EW +: EW] = EW'(v);
      return d;
   endfunction

   function automatic int sad(input logic [DW-1:0] a, input logic [DW-1:0] b);
      int s, x, y;
      s = 0;
      for (int e = 0; e < NE; e++) begin
         x = int'(a[e*EW +: EW]);
         y = int'(b[e*EW +: EW]);
         s += (x > y) ? x - y : y - x;
      end
      return s;
   endfunction

   // reference: minimum, first index holding it, and the runner-up of the multiset
   task automatic model(input int n, output int b, output int s, output int bi, output int m);
      int occ;
      b = ONES; s = ONES; bi = 0; occ = 0;
      for (int j = 0; j < n; j++) if (sc_dist[j] < b) b = sc_dist[j];
      for (int j = n - 1; j >= 0; j--) if (sc_dist[j] == b) begin bi = sc_idx[j]; occ++; end
      if (n >= 2) begin
         if (occ > 1) s = b;
         else for (int j = 0; j < n; j++) if (sc_dist[j] != b && sc_dist[j] < s) s = sc_dist[j];
      end
      m = (n >= 2 && b < (s / 2)) ? 1 : 0;
   endtask

   task automatic start_pass(input logic [DW-1:0] b, input int cnt);
      @(negedge iclk);
      i_base_load = 1'b1; i_base_desc = b; i_start = 1'b1; i_scene_cnt = 11'(cnt);
      @(negedge iclk);
      i_base_load = 1'b0; i_start = 1'b0;
   endtask

   task automatic send(input int j);
      bit ok;
      ok = 0;
      for (int g = 0; g < sc_gap[j]; g++) begin
         @(negedge iclk);
         i_s_valid = 1'b0;
         if (j == pulse_j && g == 0) begin
            i_start = 1'b1; i_base_load = 1'b1; i_base_desc = {DW{1'b1}}; i_scene_cnt = '0;
         end
      end
      @(negedge iclk);
      i_start = 1'b0; i_base_load = 1'b0;
      i_s_valid = 1'b1; i_s_desc = sc_desc[j]; i_s_idx = 11'(sc_idx[j]);
      for (int k = 0; k < 100 && !ok; k++) begin
         if (o_s_ready) begin @(posedge iclk); ok = 1; end
         else @(negedge iclk);
      end
      if (!ok) chk("handshake_timeout", 0, 1);
   endtask

   task automatic wait_result();
      r_lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge iclk);
         i_s_valid = 1'b0;
         if (o_valid) begin
            r_lat = k; r_best = int'(o_best_dist); r_second = int'(o_second_dist);
            r_idx = int'(o_best_idx); r_m = int'(o_matched);
            break;
         end
      end
      @(negedge iclk);
      chk("valid_pulse_len", int'(o_valid), 0);
   endtask

   task automatic check_result(input string tag, input int b, input int s, input int bi, input int m);
      chk({tag, "_lat"}, r_lat, LAT + 1);
      chk({tag, "_best"}, r_best, b);
      chk({tag, "_second"}, r_second, s);
      chk({tag, "_idx"}, r_idx, bi);
      chk({tag, "_matched"}, r_m, m);
   endtask

   task automatic apply_vec(input vec_t t, input string tag);
      pulse_j = -1;
      for (int j = 0; j < t.cnt; j++) begin
         sc_desc[j] = mk_desc(t.v[j], t.n[j]); sc_idx[j] = t.idx[j]; sc_gap[j] = 0;
      end
      start_pass(mk_desc(t.base_v, NE), t.cnt);
      for (int j = 0; j < t.cnt; j++) send(j);
      wait_result();
      check_result(tag, t.e_best, t.e_second, t.e_idx, t.e_m);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, int'(o_valid), 0);
      chk({tag, "_busy"}, int'(o_busy), 0);
      chk({tag, "_ready"}, int'(o_s_ready), 0);
      chk({tag, "_matched"}, int'(o_matched), 0);
      chk({tag, "_idx"}, int'(o_best_idx), 0);
      chk({tag, "_best"}, int'(o_best_dist), ONES);
      chk({tag, "_second"}, int'(o_second_dist), ONES);
   endtask

   vec_t tbl [5];

   initial begin
      int cnt, nv, bm, sm, im, mm;
      logic [DW-1:0] rb;

      tbl[0] = '{0, 3, '{10, 5, 1, 0}, '{128, 128, 128, 0}, '{0, 1, 2, 0}, 128, 640, 2, 1};
      tbl[1] = '{0, 2, '{3, 150, 0, 0}, '{100, 2, 0, 0}, '{4, 7, 0, 0}, 300, 300, 4, 0};
      tbl[2] = '{0, 1, '{1023, 0, 0, 0}, '{128, 0, 0, 0}, '{9, 0, 0, 0}, 130944, ONES, 9, 0};
      tbl[3] = '{5, 2, '{5, 0, 0, 0}, '{128, 128, 0, 0}, '{1, 3, 0, 0}, 0, 640, 1, 1};
      tbl[4] = '{0, 2, '{4, 3, 0, 0}, '{128, 128, 0, 0}, '{2, 5, 0, 0}, 384, 512, 5, 0};

      #2 irst = 1'b0;
      repeat (2) @(negedge iclk);
      check_reset_outputs("reset");
      irst = 1'b1;

      for (int t = 0; t < 5; t++) apply_vec(tbl[t], $sformatf("vec%0d", t));

      // zero-feature pass reports one cycle after start
      @(negedge iclk);
      i_start = 1'b1; i_scene_cnt = '0;
      @(negedge iclk);
      i_start = 1'b0;
      chk("cnt0_valid", int'(o_valid), 1);
      chk("cnt0_busy", int'(o_busy), 1);
      chk("cnt0_matched", int'(o_matched), 0);
      chk("cnt0_best", int'(o_best_dist), ONES);
      chk("cnt0_second", int'(o_second_dist), ONES);
      chk("cnt0_idx", int'(o_best_idx), 0);
      @(negedge iclk);
      chk("cnt0_valid_drop", int'(o_valid), 0);

      // gapped stream with start/base-load pulses that must be ignored
      for (int j = 0; j < 4; j++) begin
         sc_desc[j] = mk_desc((j == 0) ? 3 : (j == 1) ? 7 : (j == 2) ? 1 : 6, NE);
         sc_idx[j] = 10 + j; sc_gap[j] = 1;
      end
      start_pass('0, 4);
      pulse_j = 2;
      for (int j = 0; j < 4; j++) send(j);
      pulse_j = -1;
      wait_result();
      check_result("gaps", 128, 384, 12, 1);
      chk("gaps_busy_after", int'(o_busy), 0);

      // reset during drain
      for (int j = 0; j < 3; j++) begin
         sc_desc[j] = mk_desc(j + 2, NE); sc_idx[j] = j; sc_gap[j] = 0;
      end
      start_pass('0, 3);
      for (int j = 0; j < 3; j++) send(j);
      repeat (3) @(negedge iclk);
      i_s_valid = 1'b0;
      irst = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      @(negedge iclk);
      irst = 1'b1;
      nv = 0;
      repeat (20) begin @(negedge iclk); if (o_valid) nv++; end
      chk("mid_reset_no_valid", nv, 0);
      apply_vec(tbl[0], "post_reset");

      // randomized passes against the reference model
      for (int p = 0; p < 8; p++) begin
         cnt = int'($urandom_range(1, 6));
         for (int e = 0; e < NE; e++) rb[e*EW +: EW] = EW'($urandom_range(0, 1023));
         for (int j = 0; j < cnt; j++) begin
            for (int e = 0; e < NE; e++) begin
               int x;
               if (j % 2 == 0) begin
                  x = int'(rb[e*EW +: EW]) + int'($urandom_range(0, 6)) - 3;
                  if (x < 0) x = 0;
                  if (x > 1023) x = 1023;
               end else x = int'($urandom_range(0, 1023));
               sc_desc[j][e*EW +: EW] = EW'(x);
            end
            sc_idx[j] = int'($urandom_range(0, 2047));
            sc_gap[j] = int'($urandom_range(0, 2));
            sc_dist[j] = sad(rb, sc_desc[j]);
         end
         model(cnt, bm, sm, im, mm);
         start_pass(rb, cnt);
         for (int j = 0; j < cnt; j++) send(j);
         wait_result();
         check_result($sformatf("rand%0d", p), bm, sm, im, mm);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 1, expected 0");
      $fatal(1, "timeout");
   end

endmodule
